// File: rtl/his_builder_param_if.sv
// Sample/readout bundle of the dToF histogram builder. The producer (the TDC
// sequencer) uses the master modport. The histogram builder uses the slave modport.
interface his_builder_param_if #(
    parameter int NP        = 10,
    parameter int PIXEL_NUM = 3,
    parameter int CNT_W     = 8
);
    logic                             wrEn;
    logic [NP-1:0]                    data;
    logic                             accMode;
    logic                             ready;
    logic                             ovf;
    logic                             peakValid;
    logic [PIXEL_NUM-1:0][NP-1:0]     peakResult;
    logic [PIXEL_NUM-1:0][CNT_W-1:0]  peakCount;

    modport master (
        output wrEn, data, accMode,
        input  ready, ovf, peakValid, peakResult, peakCount
    );

    modport slave (
        input  wrEn, data, accMode,
        output ready, ovf, peakValid, peakResult, peakCount
    );
endinterface

// File: rtl/his_builder_param.sv
// Parametrised dToF histogram builder. It bins pixel-interleaved timestamps into
// per-pixel saturating histograms and scans every pixel in parallel for its peak bin.
module his_builder_param #(
    parameter int NP        = 10,
    parameter int PIXEL_NUM = 3,
    parameter int ACQ_NUM   = 2,
    parameter int BIN_W     = 4,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   res,
    his_builder_param_if.slave     bus
);
    localparam int BIN_NUM = 2 ** BIN_W;
    localparam int PIX_W   = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int ACQ_W   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                           r_state;
    logic [PIX_W-1:0]                 r_pix;
    logic [ACQ_W-1:0]                 r_acq;
    logic [BIN_W-1:0]                 r_b;
    logic                             r_ready;
    logic                             r_ovf;
    logic                             r_peak_valid;
    logic [PIXEL_NUM-1:0][NP-1:0]     r_peak_result;
    logic [PIXEL_NUM-1:0][CNT_W-1:0]  r_peak_count;
    logic [PIXEL_NUM-1:0][CNT_W-1:0]  r_best;
    logic [PIXEL_NUM-1:0][BIN_W-1:0]  r_best_bin;

    logic [PIXEL_NUM-1:0][BIN_NUM-1:0][CNT_W-1:0] w_hist;
    logic [PIXEL_NUM-1:0][CNT_W-1:0]  w_scan_cnt;
    logic [PIXEL_NUM-1:0]             w_take;
    logic [PIXEL_NUM-1:0][CNT_W-1:0]  w_best_next;
    logic [PIXEL_NUM-1:0][BIN_W-1:0]  w_best_bin_next;
    logic [PIXEL_NUM-1:0][NP-1:0]     w_peak_pos;

    logic                             w_accept;
    logic                             w_clear;
    logic                             w_last_pix;
    logic                             w_last_acq;
    logic                             w_scan_last;
    logic [BIN_W-1:0]                 w_bin;

    assign w_bin       = bus.data[NP-1 -: BIN_W];
    assign w_accept    = (r_state == ST_ACCUM) && r_ready && bus.wrEn;
    assign w_clear     = (r_state == ST_DONE) && !bus.accMode;
    assign w_last_pix  = (r_pix == PIX_W'(PIXEL_NUM - 1));
    assign w_last_acq  = (r_acq == ACQ_W'(ACQ_NUM - 1));
    assign w_scan_last = (r_state == ST_SCAN) && (r_b == BIN_W'(BIN_NUM - 1));

    genvar gi, gb;
    generate
        for (gi = 0; gi < PIXEL_NUM; gi++) begin : g_pix
            for (gb = 0; gb < BIN_NUM; gb++) begin : g_bin
                logic [CNT_W-1:0] r_cnt;
                logic             w_hit;

                assign w_hit = w_accept && (r_pix == PIX_W'(gi)) && (w_bin == BIN_W'(gb));

                // Counters stick at full scale rather than wrapping back to a small value.
                always_ff @(posedge clk) begin
                    if (!res) begin
                        r_cnt <= '0;
                    end else if (w_hit) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_clear) begin
                        r_cnt <= '0;
                    end
                end

                assign w_hist[gi][gb] = r_cnt;
            end

            // A strict compare keeps the earliest bin when two bins tie.
            assign w_scan_cnt[gi]      = w_hist[gi][r_b];
            assign w_take[gi]          = (w_scan_cnt[gi] > r_best[gi]);
            assign w_best_next[gi]     = w_take[gi] ? w_scan_cnt[gi] : r_best[gi];
            assign w_best_bin_next[gi] = w_take[gi] ? r_b : r_best_bin[gi];
            assign w_peak_pos[gi]      = NP'(w_best_bin_next[gi]) << (NP - BIN_W);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state       <= ST_ACCUM;
            r_pix         <= '0;
            r_acq         <= '0;
            r_b           <= '0;
            r_ready       <= 1'b1;
            r_ovf         <= 1'b0;
            r_peak_valid  <= 1'b0;
            r_peak_result <= '0;
            r_peak_count  <= '0;
            r_best        <= '0;
            r_best_bin    <= '0;
        end else begin
            r_peak_valid <= 1'b0;
            if (bus.wrEn && !r_ready) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last_pix) begin
                            r_pix <= '0;
                            r_acq <= w_last_acq ? '0 : r_acq + 1'b1;
                        end else begin
                            r_pix <= r_pix + 1'b1;
                        end
                        if (w_last_pix && w_last_acq) begin
                            r_state    <= ST_SCAN;
                            r_ready    <= 1'b0;
                            r_b        <= '0;
                            r_best     <= '0;
                            r_best_bin <= '0;
                        end
                    end
                end

                ST_SCAN: begin
                    r_best     <= w_best_next;
                    r_best_bin <= w_best_bin_next;
                    r_b        <= r_b + 1'b1;
                    // The last bin is folded in on the way out, so the result is ready in DONE.
                    if (w_scan_last) begin
                        r_state       <= ST_DONE;
                        r_peak_valid  <= 1'b1;
                        r_peak_result <= w_peak_pos;
                        r_peak_count  <= w_best_next;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_ACCUM;
                    r_ready <= 1'b1;
                    r_pix   <= '0;
                    r_acq   <= '0;
                end

                default: begin
                    r_state <= ST_ACCUM;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready      = r_ready;
    assign bus.ovf        = r_ovf;
    assign bus.peakValid  = r_peak_valid;
    assign bus.peakResult = r_peak_result;
    assign bus.peakCount  = r_peak_count;
endmodule

// File: doc/his_builder_param.md
# his_builder_param

Parametrised dToF histogram builder, successor to the fixed-size histogram FSM. It accepts pixel-interleaved TDC timestamps, bins them into one histogram per pixel, and after `ACQ_NUM` acquisitions runs a peak search on every pixel in parallel. It then emits one peak bin position and its count per pixel. It sits between the TDC/readout sequencer and the depth-output stage. Over its predecessor it adds configurable bin resolution, counter width and pixel/acquisition counts, saturating counters, an accept handshake, an overflow flag and a running-accumulation mode.

## Interface
Parameters:
- `NP`, 10: timestamp width in bits.
- `PIXEL_NUM`, 3: number of pixels (histograms) served.
- `ACQ_NUM`, 2: acquisitions per frame. One acquisition is one sample per pixel.
- `BIN_W`, 4: bin index width. `BIN_NUM = 2**BIN_W`, and `BIN_W <= NP` is required.
- `CNT_W`, 8: per-bin counter width. Counters saturate.

Ports:
- `clk`, input, 1: single clock. Everything is rising-edge.
- `res`, input, 1: synchronous, active-low reset.
- `wrEn`, input, 1: a timestamp is valid on `data`.
- `data`, input, `NP`: raw timestamp.
- `accMode`, input, 1: 0 clears all histograms after each readout; 1 keeps accumulating across frames. Sampled in DONE.
- `ready`, output, 1: the block can accept a sample this cycle.
- `ovf`, output, 1: sticky flag, set when `wrEn=1` while `ready=0`.
- `peakValid`, output, 1: one-cycle pulse when the peak outputs update.
- `peakResult`, output, `[PIXEL_NUM-1:0]` x `NP`: peak bin start time per pixel, equal to `{bin, (NP-BIN_W)'b0}`.
- `peakCount`, output, `[PIXEL_NUM-1:0]` x `CNT_W`: count in the peak bin per pixel.

## Operation
- Bin mapping: `bin = data[NP-1 -: BIN_W]`. Every timestamp maps to a valid bin.
- States: ACCUM, SCAN, DONE. The reset state is ACCUM.
- ACCUM:
  - `ready=1`.
  - On `wrEn && ready`, the counter `hist[pix][bin]` increments, saturating at `2**CNT_W-1`.
  - The pixel pointer `pix` advances, wrapping at `PIXEL_NUM-1`. On each wrap the acquisition counter `acq` advances.
  - The sample that completes pixel `PIXEL_NUM-1` of acquisition `ACQ_NUM-1` moves the FSM to SCAN.
  - Cycles with `wrEn=0` hold all pointers and counters.
- SCAN:
  - `ready=0`, and incoming samples are dropped.
  - Lasts exactly `BIN_NUM` cycles, with the scan index running `b = 0..BIN_NUM-1`.
  - For every pixel in parallel: if `hist[p][b] > best[p]` (strict), then `best[p] <= hist[p][b]` and `bestBin[p] <= b`.
  - Strict comparison means ties resolve to the lowest bin.
  - `best` and `bestBin` start at 0 when the scan begins. An all-zero histogram therefore reports bin 0 with count 0.
- DONE, one cycle:
  - `peakResult` and `peakCount` register the final `bestBin`/`best`, and `peakValid=1`.
  - If `accMode=0`, all histogram counters clear to 0. If `accMode=1`, the histograms are kept.
  - `pix` and `acq` clear to 0. The next state is ACCUM.
- `ovf` is set by any `wrEn` while `ready=0`. Only reset clears it.

## Timing
- Reset (`res=0` at a rising edge):
  - State ACCUM, all histograms 0, `pix`/`acq` 0.
  - `ready=1`, `ovf=0`, `peakValid=0`, `peakResult=0`, `peakCount=0`.
- Reset mid-SCAN or mid-DONE aborts the operation: no `peakValid`, and outputs return to their reset values.
- `ready` is registered. It drops in the cycle after the final sample is accepted and returns in the cycle after DONE.
- Latency: the final sample accepted at edge T gives SCAN in cycles T+1 .. T+`BIN_NUM` and DONE/`peakValid` in cycle T+`BIN_NUM`+1.
- Throughput: one sample per cycle in ACCUM.
- Dead time per frame: `BIN_NUM`+1 cycles.
- `peakResult` and `peakCount` hold their values until the next DONE.
- Counter width rule: increment computed at `CNT_W` bits, with a saturation compare. No wrap is allowed.

## Test plan
All scenarios use the defaults unless stated. Bin width is 64 counts.

- **Reset:** hold `res=0` for 2 cycles, then release. Expect `ready=1`, `ovf=0`, `peakValid=0`, and all `peakResult`/`peakCount`=0.
- **Basic frame:**
  - Stimulus: 108,511,1022, then 300,500,50, back-to-back.
  - `peakValid` asserts 17 cycles after the last sample is accepted.
  - Expected `peakResult` = {64, 448, 0}, `peakCount` = {1, 2, 1}. Pixel 0 is a tie between bins 1 and 4 and resolves to bin 1.
- **Gaps:** the same stream with `wrEn=0` bubbles between samples. Expect identical results, with the pointer unaffected by the bubbles.
- **Saturation:** `CNT_W=2`, `ACQ_NUM=5`, with `data`=700 for every sample. Expect `peakCount`=3 and `peakResult`=640 on all pixels.
- **Overflow:** assert `wrEn` with `data`=1023 during SCAN. Expect `ovf=1` held until reset and the frame result unchanged.
- **Accumulation mode:**
  - Run the basic frame twice with `accMode=1`. The second readout gives pixel 1 `peakCount`=4.
  - Repeat with `accMode=0`. Each readout gives pixel 1 `peakCount`=2.
  - Reset in SCAN cycle 5: no `peakValid`, and a fresh frame then gives the basic-frame result.
